// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with data memory, branch/jump resolution and MEM/WB register
module mem_wb_stage #(
    parameter int MEM_WORDS = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             Bne,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             MemtoReg,
    input  logic             RegWrite,
    input  logic             zero,
    input  logic [31:0]      ALUresult,
    input  logic [31:0]      WriteData,
    input  logic [4:0]       WriteReg,
    input  logic [31:0]      instru,
    input  logic [31:0]      pc_plus4,
    input  logic [31:0]      branch_target,
    output logic             pc_src,
    output logic [31:0]      pc_target,
    output logic             flush,
    output logic             RegWrite_wb,
    output logic             MemtoReg_wb,
    output logic [31:0]      ReadData_wb,
    output logic [31:0]      ALUresult_wb,
    output logic [4:0]       WriteReg_wb,
    output logic             mem_fault,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int          AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [29:0] DEPTH = 30'(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];

    logic [29:0]   word_idx;
    logic [AW-1:0] idx;
    logic          legal;
    logic          access;
    logic [31:0]   rd_data;
    logic          unused_bits;

    assign word_idx = ALUresult[31:2];
    assign idx      = word_idx[AW-1:0];
    assign legal    = (ALUresult[1:0] == 2'b00) && (word_idx < DEPTH);
    assign access   = MemRead | MemWrite;
    assign rd_data  = (MemRead && legal) ? mem[idx] : 32'd0;

    assign unused_bits = ^{instru[31:26], pc_plus4[27:0]};

    assign pc_src    = Jump | (Branch & zero) | (Bne & ~zero);
    assign pc_target = Jump ? {pc_plus4[31:28], instru[25:0], 2'b00} : branch_target;
    assign flush     = pc_src;

    // Memory is not reset; a store landing on an edge while reset is held is dropped
    always_ff @(posedge clk) begin
        if (rst_n && MemWrite && legal) begin
            mem[idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_wb  <= 1'b0;
            MemtoReg_wb  <= 1'b0;
            ReadData_wb  <= 32'd0;
            ALUresult_wb <= 32'd0;
            WriteReg_wb  <= 5'd0;
        end else begin
            RegWrite_wb  <= RegWrite;
            MemtoReg_wb  <= MemtoReg;
            ReadData_wb  <= rd_data;
            ALUresult_wb <= ALUresult;
            // Zero the destination when not writing so forwarding never matches it
            WriteReg_wb  <= RegWrite ? WriteReg : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_fault <= 1'b0;
            taken_cnt <= '0;
        end else begin
            if (access && !legal) begin
                mem_fault <= 1'b1;
            end
            if (pc_src && (taken_cnt != {CNT_W{1'b1}})) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard testbench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        Jump, Branch, Bne, MemRead, MemWrite, MemtoReg, RegWrite, zero;
    logic [31:0] ALUresult, WriteData, instru, pc_plus4, branch_target;
    logic [4:0]  WriteReg;
    logic        pc_src, flush, RegWrite_wb, MemtoReg_wb, mem_fault;
    logic [31:0] pc_target, ReadData_wb, ALUresult_wb;
    logic [4:0]  WriteReg_wb;
    logic [1:0]  taken_cnt;

    mem_wb_stage #(.MEM_WORDS(64), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .Jump(Jump), .Branch(Branch), .Bne(Bne), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .zero(zero),
        .ALUresult(ALUresult), .WriteData(WriteData), .WriteReg(WriteReg),
        .instru(instru), .pc_plus4(pc_plus4), .branch_target(branch_target),
        .pc_src(pc_src), .pc_target(pc_target), .flush(flush),
        .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
        .ReadData_wb(ReadData_wb), .ALUresult_wb(ALUresult_wb), .WriteReg_wb(WriteReg_wb),
        .mem_fault(mem_fault), .taken_cnt(taken_cnt)
    );

    typedef struct {
        logic        rw;
        logic        mtr;
        logic        chk_rd;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        fault;
        logic [1:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mm [64];
    logic        fault_m;
    logic [1:0]  cnt_m;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] addr_set [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Jump = 0; Branch = 0; Bne = 0; MemRead = 0; MemWrite = 0;
        MemtoReg = 0; RegWrite = 0; zero = 0;
        ALUresult = 0; WriteData = 0; WriteReg = 0;
        instru = 0; pc_plus4 = 0; branch_target = 0;
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_rw"}, {31'd0, RegWrite_wb}, 32'd0);
        check({tag, "_mtr"}, {31'd0, MemtoReg_wb}, 32'd0);
        check({tag, "_rd"}, ReadData_wb, 32'd0);
        check({tag, "_alu"}, ALUresult_wb, 32'd0);
        check({tag, "_wr"}, {27'd0, WriteReg_wb}, 32'd0);
        check({tag, "_fault"}, {31'd0, mem_fault}, 32'd0);
        check({tag, "_cnt"}, {30'd0, taken_cnt}, 32'd0);
    endtask

    // Inputs are already driven (just after a posedge); check redirect, model the edge, then compare WB
    task automatic step();
        exp_t        e;
        logic        legal, take;
        logic [29:0] wi;
        logic [31:0] tgt;
        #2;
        take = Jump | (Branch & zero) | (Bne & ~zero);
        tgt  = Jump ? {pc_plus4[31:28], instru[25:0], 2'b00} : branch_target;
        check("pc_src", {31'd0, pc_src}, {31'd0, take});
        check("flush", {31'd0, flush}, {31'd0, take});
        check("pc_target", pc_target, tgt);
        wi    = ALUresult[31:2];
        legal = (ALUresult[1:0] == 2'b00) && (wi < 30'd64);
        e.chk_rd = MemRead;
        e.rd     = (MemRead && legal) ? mm[wi[5:0]] : 32'd0;
        if (MemWrite && legal) mm[wi[5:0]] = WriteData;
        if ((MemRead || MemWrite) && !legal) fault_m = 1'b1;
        if (take && cnt_m != 2'd3) cnt_m = cnt_m + 2'd1;
        e.rw    = RegWrite;
        e.mtr   = MemtoReg;
        e.alu   = ALUresult;
        e.wr    = RegWrite ? WriteReg : 5'd0;
        e.fault = fault_m;
        e.cnt   = cnt_m;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("RegWrite_wb", {31'd0, RegWrite_wb}, {31'd0, e.rw});
        check("MemtoReg_wb", {31'd0, MemtoReg_wb}, {31'd0, e.mtr});
        check("ALUresult_wb", ALUresult_wb, e.alu);
        check("WriteReg_wb", {27'd0, WriteReg_wb}, {27'd0, e.wr});
        if (e.chk_rd) check("ReadData_wb", ReadData_wb, e.rd);
        check("mem_fault", {31'd0, mem_fault}, {31'd0, e.fault});
        check("taken_cnt", {30'd0, taken_cnt}, {30'd0, e.cnt});
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        idle(); MemWrite = 1; ALUresult = a; WriteData = d; step();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [4:0] r);
        idle(); MemRead = 1; ALUresult = a; MemtoReg = 1; RegWrite = 1; WriteReg = r; step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mm[i] = 32'd0;
        fault_m = 0;
        cnt_m   = 0;
        addr_set[0] = 32'h0;  addr_set[1] = 32'h4;  addr_set[2] = 32'h8;
        addr_set[3] = 32'hFC; addr_set[4] = 32'h100; addr_set[5] = 32'h6;
        idle();
        rst_n = 0;
        #3;
        check_zero_state("reset");
        @(posedge clk); #1;
        rst_n = 1;

        do_store(32'h8, 32'hDEADBEEF);
        do_load(32'h8, 5'd9);

        idle(); RegWrite = 0; WriteReg = 5'd7; ALUresult = 32'h1234; step();

        do_load(32'h6, 5'd3);
        do_load(32'h8, 5'd4);

        do_store(32'h0, 32'hA5A5_0000);
        do_store(32'hFC, 32'h0000_5A5A);
        do_store(32'h100, 32'hBADBAD00);
        do_load(32'h0, 5'd1);
        do_load(32'hFC, 5'd2);
        do_load(32'h8, 5'd5);

        idle(); Branch = 1; zero = 1; branch_target = 32'h40; step();
        idle(); Bne = 1; zero = 1; branch_target = 32'h80; step();
        idle(); Bne = 1; zero = 0; branch_target = 32'h84; step();
        idle(); Branch = 1; zero = 0; branch_target = 32'h88; step();
        idle(); Jump = 1; zero = 0; pc_plus4 = 32'h1000_0004; instru = 32'h0800_0010;
        branch_target = 32'h99; step();
        idle(); Jump = 1; zero = 1; pc_plus4 = 32'h0000_0004; instru = 32'hFC00_0010; step();

        do_store(32'h8, 32'h11);
        idle(); MemRead = 1; MemWrite = 1; ALUresult = 32'h8; WriteData = 32'h22;
        RegWrite = 1; WriteReg = 5'd6; step();
        do_load(32'h8, 5'd6);

        do_store(32'h10, 32'h77);
        idle(); MemWrite = 1; ALUresult = 32'h10; WriteData = 32'h55;
        Branch = 1; zero = 1; RegWrite = 1; WriteReg = 5'd8;
        rst_n = 0;
        #2;
        check_zero_state("rst_async");
        @(posedge clk); #1;
        check_zero_state("rst_held");
        rst_n = 1;
        fault_m = 0;
        cnt_m   = 0;
        do_load(32'h10, 5'd10);

        for (int i = 0; i < 5; i++) begin
            idle(); Branch = 1; zero = 1; branch_target = 32'h40 + 32'(i); step();
        end

        for (int i = 0; i < 24; i++) begin
            idle();
            MemRead   = 1'($urandom_range(0, 1));
            MemWrite  = 1'($urandom_range(0, 1));
            ALUresult = addr_set[$urandom_range(0, 5)];
            WriteData = $urandom;
            RegWrite  = 1'($urandom_range(0, 1));
            MemtoReg  = MemRead;
            WriteReg  = 5'($urandom_range(0, 31));
            Branch    = 1'($urandom_range(0, 1));
            Bne       = 1'($urandom_range(0, 1));
            Jump      = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            instru    = $urandom;
            pc_plus4  = $urandom;
            branch_target = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
